priority_grant_fsm: RTL and testbench
=====================================

Name: priority_grant_fsm

Overview:
- Three-requester arbiter implemented as a Moore FSM with fixed priority r[1] > r[2] > r[3].
- Once a requester is granted, it keeps the grant until it drops its request. There is no preemption by a higher-priority request.
- Sits between three request sources and a shared resource. Produces one-hot (or all-zero) grants.
- Target implementation size is 120-400 lines of RTL, including state encoding, next-state logic and assertions.

Parameters:
- None. Requester count is fixed at 3 and priority order is fixed.

Ports:
- clk     input   1  rising-edge clock; the only clock.
- resetn  input   1  synchronous, active-low reset, sampled on rising clk.
- r       input   3  request vector, indexed [3:1]. r[1] has highest priority, r[3] lowest.
- g       output  3  grant vector, indexed [3:1]. At most one bit set.

Behaviour:
- States:
  - A: idle, no grant.
  - B: grant to requester 1.
  - C: grant to requester 2.
  - D: grant to requester 3.
  - Encode as a 2-bit register: A=0, B=1, C=2, D=3.
- Reset: if resetn==0 at a rising clk edge, state becomes A and g=000 after that edge. Reset is synchronous only; asserting resetn low between edges has no effect until the next rising edge. Reset has priority over all transitions, including mid-grant.
- Outputs are Moore, decoded purely from state with no combinational path from r:
  - g[1] = (state==B)
  - g[2] = (state==C)
  - g[3] = (state==D)
  - In A, g=000.
- Transitions, evaluated at each rising clk when resetn==1:
  - A: r[1] -> B; else r[2] -> C; else r[3] -> D; else stay A.
  - B: r[1] ? stay B : go to A.
  - C: r[2] ? stay C : go to A.
  - D: r[3] ? stay D : go to A.
  - In B, C and D only the owning request bit is examined; other bits are ignored.
- Latency:
  - A request seen at an edge produces its grant on g immediately after that edge (1 cycle).
  - Grant release: dropping the owning request causes g=000 after the next edge.
  - A new grant follows at the earliest one cycle after release, because the FSM always passes through A. No grant-to-grant handoff happens in a single cycle.
- Simultaneous requests in A: the lowest index wins, e.g. r=111 -> B, r=110 -> C.
- Illegal or unreachable state (defensive; none exists with 2-bit encoding): next state A, g=000.
- No X may propagate to g after the first reset edge.

Decomposition:
- Shared package holds:
  - state typedef (enum logic [1:0] {ST_IDLE, ST_G1, ST_G2, ST_G3});
  - constant N_REQ=3.
- Single module; no sub-module is warranted.
- Use one sequential always block for the state register and one combinational block for next state. Output decode can be continuous assigns.
- Include assertions:
  - $onehot0(g);
  - g stays stable while the owning request stays high.

Test Plan:
1. Hold resetn=0 with r=001 across 2 edges -> g=000. Release resetn with r=001 -> g=001 (requester 1 granted) after the next edge. Re-assert resetn=0 mid-grant -> g=000 after that edge; g must not change before the edge.
2. Start from A with r=000 for 2 cycles -> g=000. Then r=111 -> g=001 after 1 edge, held while r stays 111.
3. Continue from scenario 2: r=110 -> g=000 after next edge, then g=010 on the following edge. Then r=100 -> g=000, then g=100. Then r=000 -> g=000.
4. Starvation/non-preemption: in grant-3 state (g=100), raise r=111 -> g stays 100 (r[3] still high). Then r=011 -> g=000, then g=001.
5. Priority in idle: from A apply each of r=010 -> g=010, r=100 -> g=100, r=011 -> g=001, r=110 -> g=010. Return through r=000 between cases.
6. Randomized: about 1000 half-cycle random r changes with resetn=0 roughly 1/64 of the time. Compare g against a golden transition-table model every half-cycle; g must never be multi-hot or X.

Source files
------------

// File: rtl/priority_grant_fsm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : priority_grant_fsm_pkg
//  Purpose  : Shared types and constants for the three-requester
//             fixed-priority, non-preemptive grant FSM.
//  Revision : 1.0 - initial release
// ============================================================================
package priority_grant_fsm_pkg;

    // Number of requesters; priority order is fixed (index 1 highest).
    localparam int N_REQ = 3;

    // Arbiter state, explicit 2-bit encoding: idle, then one state per owner.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_G1   = 2'd1,
        ST_G2   = 2'd2,
        ST_G3   = 2'd3
    } state_t;

endpackage : priority_grant_fsm_pkg
`default_nettype wire

// File: rtl/priority_grant_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : priority_grant_fsm
//  Purpose  : Three-requester Moore arbiter, fixed priority r[1]>r[2]>r[3].
//             A granted requester keeps the grant until it drops its request;
//             every release passes through idle, so grants never hand off
//             directly from one owner to another.
//  Revision : 1.0 - initial release
// ============================================================================
module priority_grant_fsm
    import priority_grant_fsm_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic [N_REQ:1]   r,
    output logic [N_REQ:1]   g
);

    state_t r_state;
    state_t w_next_state;

    // State register: synchronous active-low reset overrides every transition.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: idle picks the lowest-index request; an owner only watches its own bit.
    always_comb begin
        w_next_state = ST_IDLE;
        case (r_state)
            ST_IDLE: begin
                if (r[1]) begin
                    w_next_state = ST_G1;
                end else if (r[2]) begin
                    w_next_state = ST_G2;
                end else if (r[3]) begin
                    w_next_state = ST_G3;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_G1:   w_next_state = r[1] ? ST_G1 : ST_IDLE;
            ST_G2:   w_next_state = r[2] ? ST_G2 : ST_IDLE;
            ST_G3:   w_next_state = r[3] ? ST_G3 : ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Moore output decode: grant depends on state only, never on r.
    always_comb begin
        g = '0;
        case (r_state)
            ST_G1:   g = 3'b001;
            ST_G2:   g = 3'b010;
            ST_G3:   g = 3'b100;
            default: g = '0;
        endcase
    end

    // Grant vector is always one-hot or empty.
    a_onehot0_g : assert property (@(posedge clk) $onehot0(g));

    // A held owning request keeps the grant unchanged across the next edge.
    a_grant_held : assert property (@(posedge clk)
        (resetn && ((g & r) != '0)) |=> $stable(g));

endmodule : priority_grant_fsm
`default_nettype wire

// File: tb/tb_priority_grant_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_priority_grant_fsm
//  Purpose  : Self-checking bench for priority_grant_fsm. A reference model
//             tracks the current owner as an integer and pushes the expected
//             grant into a scoreboard queue every edge; a monitor pops and
//             compares, and rechecks that g holds between edges.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_priority_grant_fsm;

    logic       clk;
    logic       resetn;
    logic [3:1] r;
    logic [3:1] g;

    int errors = 0;
    int checks = 0;

    logic [3:1] sb_q[$];
    bit         armed = 0;

    priority_grant_fsm dut (
        .clk    (clk),
        .resetn (resetn),
        .r      (r),
        .g      (g)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point shared by every checker.
    task automatic check(input string name, input logic [3:1] exp);
        checks++;
        if ($isunknown(g) || (g !== exp) || !$onehot0(g)) begin
            errors++;
            $display("FAIL %s at %0t: g=%b expected %b", name, $time, g, exp);
        end
    endtask

    // Reference model: owner 0 means nobody, otherwise the granted index.
    initial begin : p_model
        int owner;
        logic [3:1] exp;
        owner = 0;
        forever begin
            @(posedge clk);
            if (!resetn) begin
                armed = 1;
                owner = 0;
            end else if (owner != 0) begin
                if (!r[owner]) owner = 0;
            end else begin
                for (int i = 1; i <= 3; i++) begin
                    if (owner == 0 && r[i]) owner = i;
                end
            end
            exp = '0;
            if (owner != 0) exp[owner] = 1'b1;
            if (armed) sb_q.push_back(exp);
        end
    end

    // Monitor: pop after each edge, then confirm g holds through the cycle.
    initial begin : p_monitor
        logic [3:1] cur;
        bit have;
        have = 0;
        cur  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (armed) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_empty at %0t: g=%b expected a queued value", $time, g);
                end else begin
                    cur  = sb_q.pop_front();
                    have = 1;
                    check("scoreboard", cur);
                end
            end
            #3;
            if (have) check("hold_after_edge", cur);
            @(negedge clk);
            #4;
            if (have) check("hold_mid_cycle", cur);
        end
    end

    // Drive inputs mid-cycle, then check the constant expected grant after the edge.
    task automatic step(input logic [3:1] rv, input logic rn, input logic [3:1] expg, input string name);
        @(negedge clk);
        #2;
        r      = rv;
        resetn = rn;
        @(posedge clk);
        #1;
        check(name, expg);
    endtask

    initial begin : p_stim
        resetn = 1'b0;
        r      = 3'b001;

        // Reset held with a pending request.
        step(3'b001, 1'b0, 3'b000, "reset_hold_0");
        step(3'b001, 1'b0, 3'b000, "reset_hold_1");
        step(3'b001, 1'b1, 3'b001, "release_grant1");
        // Reset mid-grant: no effect until the edge.
        @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("reset_before_edge", 3'b001);
        @(posedge clk);
        #1;
        check("reset_mid_grant", 3'b000);

        // Idle, then all request; requester 1 wins and holds.
        step(3'b000, 1'b1, 3'b000, "idle_0");
        step(3'b000, 1'b1, 3'b000, "idle_1");
        step(3'b111, 1'b1, 3'b001, "all_req_g1");
        step(3'b111, 1'b1, 3'b001, "all_req_hold");

        // Release passes through idle before next grant.
        step(3'b110, 1'b1, 3'b000, "rel1_idle");
        step(3'b110, 1'b1, 3'b010, "then_g2");
        step(3'b100, 1'b1, 3'b000, "rel2_idle");
        step(3'b100, 1'b1, 3'b100, "then_g3");

        // Non-preemption of requester 3.
        step(3'b111, 1'b1, 3'b100, "no_preempt_0");
        step(3'b111, 1'b1, 3'b100, "no_preempt_1");
        step(3'b011, 1'b1, 3'b000, "rel3_idle");
        step(3'b011, 1'b1, 3'b001, "then_g1");
        step(3'b000, 1'b1, 3'b000, "drop_all");

        // Priority from idle.
        step(3'b010, 1'b1, 3'b010, "prio_010");
        step(3'b000, 1'b1, 3'b000, "prio_ret0");
        step(3'b100, 1'b1, 3'b100, "prio_100");
        step(3'b000, 1'b1, 3'b000, "prio_ret1");
        step(3'b011, 1'b1, 3'b001, "prio_011");
        step(3'b000, 1'b1, 3'b000, "prio_ret2");
        step(3'b110, 1'b1, 3'b010, "prio_110");
        step(3'b000, 1'b1, 3'b000, "prio_ret3");

        // Random half-cycle changes; reset roughly 1/64 of the time.
        for (int n = 0; n < 500; n++) begin
            @(posedge clk);
            #2;
            r      = 3'($urandom_range(7));
            resetn = ($urandom_range(63) != 0);
            @(negedge clk);
            #2;
            r      = 3'($urandom_range(7));
            resetn = ($urandom_range(63) != 0);
        end

        @(posedge clk);
        #8;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_priority_grant_fsm
`default_nettype wire
